marie_core: RTL

Synthesizable, parametrised accumulator CPU core executing the team's MARIE-style 4-bit-opcode instruction set against an external single-port synchronous RAM. Fetch/decode/execute runs as an explicit state machine, with registers PC, IR, MBR and AC. It adds signed Skipcond, Subt, Input/Output ports with valid/ready handshakes, and optional indirect instructions. It sits between the RAM (one-cycle read latency) and the testbench or I/O fabric.

---
 rtl/marie_pkg.sv | 56 +++++
 rtl/marie_alu.sv | 23 ++
 rtl/marie_core.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/marie_pkg.sv
// marie_pkg: shared opcode/state types, Skipcond codes and ALU select
// for the marie_core accumulator CPU.
package marie_pkg;

  typedef enum logic [3:0] {
    OP_JNS    = 4'h0,
    OP_LOAD   = 4'h1,
    OP_STORE  = 4'h2,
    OP_ADD    = 4'h3,
    OP_SUBT   = 4'h4,
    OP_INPUT  = 4'h5,
    OP_OUTPUT = 4'h6,
    OP_HALT   = 4'h7,
    OP_SKIP   = 4'h8,
    OP_JUMP   = 4'h9,
    OP_CLEAR  = 4'hA,
    OP_ADDI   = 4'hB,
    OP_JUMPI  = 4'hC,
    OP_LOADI  = 4'hD,
    OP_STOREI = 4'hE,
    OP_NOP    = 4'hF
  } opcode_t;

  typedef enum logic [3:0] {
    S_FETCH,
    S_FCAP,
    S_DECODE,
    S_RD_REQ,
    S_RD_CAP,
    S_EXEC,
    S_WR,
    S_IN,
    S_OUT,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB
  } alu_op_t;

  localparam logic [1:0] SKIP_LT    = 2'b00;
  localparam logic [1:0] SKIP_EQ    = 2'b01;
  localparam logic [1:0] SKIP_GT    = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

  function automatic alu_op_t alu_sel(input opcode_t op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUBT:         return ALU_SUB;
      default:         return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/marie_alu.sv
// marie_alu: combinational pass/add/sub datapath for the accumulator.
// Results wrap modulo 2^WIDTH.
module marie_alu
  import marie_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = b;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/marie_core.sv
// marie_core: multi-cycle MARIE accumulator CPU on a 1-cycle-latency RAM.
// Define MARIE_INDIRECT_EN to build JnS/AddI/JumpI/LoadI/StoreI.
module marie_core
  import marie_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  halted,
  output logic                  retire,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
  localparam int PAD = DATA_WIDTH - ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d, mbr_q, mbr_d;
  logic [DATA_WIDTH-1:0] ac_q, ac_d, wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] out_q, alu_y;
  logic                  re, we, ret;
  opcode_t               op;
  logic [ADDR_WIDTH-1:0] x;
  logic [1:0]            cond;
  logic                  skip;
`ifdef MARIE_INDIRECT_EN
  logic                  ind_q, ind_d;
`endif

  assign op   = opcode_t'(ir_q[DATA_WIDTH-1 -: 4]);
  assign x    = ir_q[ADDR_WIDTH-1:0];
  assign cond = ir_q[ADDR_WIDTH-1 -: 2];

  always_comb begin
    skip = 1'b0;
    case (cond)
      SKIP_LT: skip = ac_q[DATA_WIDTH-1];
      SKIP_EQ: skip = (ac_q == '0);
      SKIP_GT: skip = !ac_q[DATA_WIDTH-1] && (ac_q != '0);
      default: skip = 1'b0;
    endcase
  end

  marie_alu #(
    .WIDTH(DATA_WIDTH)
  ) u_alu (
    .a (ac_q),
    .b (mbr_q),
    .op(alu_sel(op)),
    .y (alu_y)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mbr_d   = mbr_q;
    ac_d    = ac_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    re      = 1'b0;
    we      = 1'b0;
    ret     = 1'b0;
`ifdef MARIE_INDIRECT_EN
    ind_d   = ind_q;
`endif
    case (state_q)
      S_FETCH: begin
        addr_d  = pc_q;
        re      = 1'b1;
        state_d = S_FCAP;
      end
      S_FCAP: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + PC_ONE;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
`ifdef MARIE_INDIRECT_EN
        ind_d   = 1'b0;
`endif
        case (op)
          OP_LOAD, OP_ADD, OP_SUBT: state_d = S_RD_REQ;
          OP_STORE:  state_d = S_WR;
          OP_INPUT:  state_d = S_IN;
          OP_OUTPUT: state_d = S_OUT;
          OP_HALT:   state_d = S_HALT;
          OP_SKIP: begin
            ret = 1'b1;
            if (skip) pc_d = pc_q + PC_ONE;
          end
          OP_JUMP: begin
            ret  = 1'b1;
            pc_d = x;
          end
          OP_CLEAR: begin
            ret  = 1'b1;
            ac_d = '0;
          end
`ifdef MARIE_INDIRECT_EN
          OP_JNS: state_d = S_WR;
          OP_ADDI, OP_JUMPI,
          OP_LOADI, OP_STOREI: state_d = S_RD_REQ;
`endif
          default: ret = 1'b1;
        endcase
      end
      S_RD_REQ: begin
        addr_d  = x;
`ifdef MARIE_INDIRECT_EN
        if (ind_q) addr_d = mbr_q[ADDR_WIDTH-1:0];
`endif
        re      = 1'b1;
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        mbr_d   = mem_rdata;
        state_d = S_EXEC;
`ifdef MARIE_INDIRECT_EN
        // first pass of an indirect op fetched the pointer
        if (op == OP_JUMPI) begin
          pc_d    = mem_rdata[ADDR_WIDTH-1:0];
          ret     = 1'b1;
          state_d = S_FETCH;
        end else if (op == OP_STOREI) begin
          state_d = S_WR;
        end else if (!ind_q && (op == OP_ADDI || op == OP_LOADI)) begin
          ind_d   = 1'b1;
          state_d = S_RD_REQ;
        end
`endif
      end
      S_EXEC: begin
        ac_d    = alu_y;
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_WR: begin
        addr_d  = x;
        wdata_d = ac_q;
`ifdef MARIE_INDIRECT_EN
        if (op == OP_STOREI) addr_d = mbr_q[ADDR_WIDTH-1:0];
        if (op == OP_JNS) begin
          wdata_d = {{PAD{1'b0}}, pc_q};
          pc_d    = x + PC_ONE;
        end
`endif
        we      = 1'b1;
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_IN: begin
        if (in_valid) begin
          ac_d    = in_data;
          ret     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          ret     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mbr_q   <= '0;
      ac_q    <= '0;
      addr_q  <= RESET_PC;
      wdata_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mbr_q   <= mbr_d;
      ac_q    <= ac_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      out_q   <= out_data;
    end
  end

`ifdef MARIE_INDIRECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ind_q <= 1'b0;
    else     ind_q <= ind_d;
  end
`endif

  // reset parks the FSM in FETCH, so the read strobe is masked by rst
  assign mem_addr  = addr_d;
  assign mem_re    = re && !rst;
  assign mem_we    = we;
  assign mem_wdata = wdata_d;
  assign in_ready  = (state_q == S_IN);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = (state_q == S_OUT) ? ac_q : out_q;
  assign halted    = (state_q == S_HALT);
  assign retire    = ret;
  assign pc        = pc_q;
  assign ac        = ac_q;

endmodule
